branch_target_table: RTL and testbench

Programmable, parametrised branch-target table for the fetch stage. It maps a branch key to an absolute instruction address. After reset it self-initialises from the default program map, then serves registered lookups. It accepts run-time writes and invalidations, so the branch map can be changed without a re-synthesis. It replaces the fixed combinational key-to-address map and feeds the PC-select mux.

---
 rtl/branch_target_table_pkg.sv | 37 +++
 rtl/branch_table_mem.sv | 72 +++++++
 rtl/branch_target_table.sv | 98 +++++++++
 tb/tb_branch_target_table.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_target_table_pkg.sv
// Shared definitions for the branch-target table: default widths, FSM states
// and the power-on branch map loaded by the init sweep.
package branch_pkg;

  localparam int KEY_W_DEF  = 5;
  localparam int ADDR_W_DEF = 12;
  localparam int MAP_DEPTH  = 2 ** KEY_W_DEF;

  typedef enum logic {
    INIT,
    RUN
  } btt_state_t;

  localparam logic [ADDR_W_DEF-1:0] DEFAULT_MAP [MAP_DEPTH] = '{
    0: 12'd4,  1: 12'd6,  2: 12'd108, 3: 12'd18, 4: 12'd78, 5: 12'd82,
    6: 12'd52, 7: 12'd53, 8: 12'd61,  9: 12'd68, 10: 12'd73,
    default: 12'd0
  };

  localparam logic [MAP_DEPTH-1:0] DEFAULT_VALID = 32'h0000_07ff;

  // Entries beyond the stored map (larger key spaces) default to invalid/0.
  function automatic logic [ADDR_W_DEF-1:0] default_target(input int idx);
    logic [ADDR_W_DEF-1:0] t;
    t = '0;
    if (idx >= 0 && idx < MAP_DEPTH) t = DEFAULT_MAP[idx[KEY_W_DEF-1:0]];
    return t;
  endfunction

  function automatic logic default_valid(input int idx);
    logic v;
    v = 1'b0;
    if (idx >= 0 && idx < MAP_DEPTH) v = DEFAULT_VALID[idx[KEY_W_DEF-1:0]];
    return v;
  endfunction

endpackage

// File: rtl/branch_table_mem.sv
// Target array plus valid vector: one synchronous write port and one registered
// read port with write-first bypass. Read outputs hold when no read is issued.
module branch_table_mem #(
  parameter int KEY_W  = 5,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic              wr_valid,
  input  logic              rd_en,
  input  logic [KEY_W-1:0]  rd_key,
  output logic              rd_hit,
  output logic [ADDR_W-1:0] rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic              rd_hit_q, rd_hit_d;
  logic [ADDR_W-1:0] rd_data_q, rd_data_d;
  logic              wr_in_range, rd_in_range, bypass;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  assign wr_in_range = (32'(wr_key) < 32'(DEPTH));
  assign rd_in_range = (32'(rd_key) < 32'(DEPTH));
  assign wr_idx      = wr_key[IDX_W-1:0];
  assign rd_idx      = rd_key[IDX_W-1:0];
  assign bypass      = wr_en && wr_in_range && (wr_key == rd_key);

  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem_q[wr_idx]   <= wr_data;
      valid_q[wr_idx] <= wr_valid;
    end
  end

  always_comb begin
    rd_hit_d  = rd_hit_q;
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (!rd_in_range) begin
        rd_hit_d  = 1'b0;
        rd_data_d = '0;
      end else if (bypass) begin
        rd_hit_d  = wr_valid;
        rd_data_d = wr_valid ? wr_data : '0;
      end else begin
        rd_hit_d  = valid_q[rd_idx];
        rd_data_d = valid_q[rd_idx] ? mem_q[rd_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_hit_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_hit_q  <= rd_hit_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_hit  = rd_hit_q;
  assign rd_data = rd_data_q;

endmodule

// File: rtl/branch_target_table.sv
// Programmable branch-target table: sweeps the default map in after reset,
// then serves registered lookups and run-time writes/invalidations.
module branch_target_table
  import branch_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_done,
  input  logic              lu_en,
  input  logic [KEY_W-1:0]  lu_key,
  output logic              lu_valid,
  output logic              lu_hit,
  output logic [ADDR_W-1:0] lu_target,
  input  logic              wr_en,
  input  logic              wr_clear,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [ADDR_W-1:0] wr_target
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  btt_state_t        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              lu_valid_q, lu_valid_d;
  logic              mem_wr_en, mem_wr_valid, mem_rd_en;
  logic [KEY_W-1:0]  mem_wr_key;
  logic [ADDR_W-1:0] mem_wr_data;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lu_valid_d   = 1'b0;
    mem_wr_en    = 1'b0;
    mem_wr_key   = '0;
    mem_wr_data  = '0;
    mem_wr_valid = 1'b0;
    mem_rd_en    = 1'b0;
    case (state_q)
      RUN: begin
        // wr_en has priority: a simultaneous clear is a plain write.
        mem_wr_en    = wr_en | wr_clear;
        mem_wr_key   = wr_key;
        mem_wr_data  = wr_en ? wr_target : '0;
        mem_wr_valid = wr_en;
        mem_rd_en    = lu_en;
        lu_valid_d   = lu_en;
      end
      default: begin
        mem_wr_en    = 1'b1;
        mem_wr_key   = KEY_W'(cnt_q);
        mem_wr_data  = ADDR_W'(default_target(int'(cnt_q)));
        mem_wr_valid = default_valid(int'(cnt_q));
        cnt_d        = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      lu_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lu_valid_q <= lu_valid_d;
    end
  end

  branch_table_mem #(
    .KEY_W (KEY_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mem_wr_en),
    .wr_key  (mem_wr_key),
    .wr_data (mem_wr_data),
    .wr_valid(mem_wr_valid),
    .rd_en   (mem_rd_en),
    .rd_key  (lu_key),
    .rd_hit  (lu_hit),
    .rd_data (lu_target)
  );

  assign init_done = (state_q == RUN);
  assign lu_valid  = lu_valid_q;

endmodule

// File: tb/tb_branch_target_table.sv
// Bench for branch_target_table: a full-size and a DEPTH=16 instance share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_branch_target_table;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lu_en = 1'b0, wr_en = 1'b0, wr_clear = 1'b0;
  logic [4:0]  lu_key = '0, wr_key = '0;
  logic [11:0] wr_target = '0;

  logic        a_done, a_valid, a_hit, b_done, b_valid, b_hit;
  logic [11:0] a_tgt, b_tgt;

  always #5 clk = ~clk;

  branch_target_table #(.KEY_W(5), .ADDR_W(12), .DEPTH(32)) dut_a (
    .clk(clk), .reset(reset), .init_done(a_done),
    .lu_en(lu_en), .lu_key(lu_key), .lu_valid(a_valid), .lu_hit(a_hit), .lu_target(a_tgt),
    .wr_en(wr_en), .wr_clear(wr_clear), .wr_key(wr_key), .wr_target(wr_target)
  );

  branch_target_table #(.KEY_W(5), .ADDR_W(12), .DEPTH(16)) dut_b (
    .clk(clk), .reset(reset), .init_done(b_done),
    .lu_en(lu_en), .lu_key(lu_key), .lu_valid(b_valid), .lu_hit(b_hit), .lu_target(b_tgt),
    .wr_en(wr_en), .wr_clear(wr_clear), .wr_key(wr_key), .wr_target(wr_target)
  );

  // ---------------- behavioural model ----------------
  int  def_map [11] = '{4, 6, 108, 18, 78, 82, 52, 53, 61, 68, 73};
  int  depth_of [2] = '{32, 16};
  int  m_tgt [2][32];
  bit  m_val [2][32];
  int  m_sweep [2];
  bit  e_valid [2], e_hit [2], e_done [2];
  int  e_tgt [2];
  bit  model_ok = 1'b0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int dep, wk, lk;
      dep = depth_of[d];
      wk  = int'(wr_key);
      lk  = int'(lu_key);
      if (reset) begin
        m_sweep[d] = 0;
        e_valid[d] = 0;
        e_hit[d]   = 0;
        e_tgt[d]   = 0;
      end else if (m_sweep[d] < dep) begin
        m_tgt[d][m_sweep[d]] = (m_sweep[d] < 11) ? def_map[m_sweep[d]] : 0;
        m_val[d][m_sweep[d]] = (m_sweep[d] < 11);
        m_sweep[d]++;
        e_valid[d] = 0;
      end else begin
        if (wr_en && wk < dep) begin
          m_tgt[d][wk] = int'(wr_target);
          m_val[d][wk] = 1;
        end else if (wr_clear && wk < dep) begin
          m_tgt[d][wk] = 0;
          m_val[d][wk] = 0;
        end
        e_valid[d] = lu_en;
        if (lu_en) begin
          e_hit[d] = (lk < dep) && m_val[d][lk];
          e_tgt[d] = e_hit[d] ? m_tgt[d][lk] : 0;
        end
      end
      e_done[d] = (m_sweep[d] >= dep);
    end
    if (reset) model_ok = 1'b1;
  end

  // ---------------- comparison ----------------
  int checks = 0;
  int errors = 0;

  bit lit_en [2] = '{0, 0}, lit_ht [2] = '{0, 0}, lit_den [2] = '{0, 0};
  bit lit_v [2], lit_h [2], lit_d [2];
  int lit_t [2];

  bit o_valid [2], o_hit [2], o_done [2];
  int o_tgt [2];
  assign o_valid[0] = a_valid;  assign o_valid[1] = b_valid;
  assign o_hit[0]   = a_hit;    assign o_hit[1]   = b_hit;
  assign o_done[0]  = a_done;   assign o_done[1]  = b_done;
  assign o_tgt[0]   = int'(a_tgt);
  assign o_tgt[1]   = int'(b_tgt);

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %0d want %0d", nm, d, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      for (int d = 0; d < 2; d++) begin
        chk("lu_valid", d, int'(o_valid[d]), int'(e_valid[d]));
        chk("lu_hit", d, int'(o_hit[d]), int'(e_hit[d]));
        chk("lu_target", d, o_tgt[d], e_tgt[d]);
        chk("init_done", d, int'(o_done[d]), int'(e_done[d]));
        if (lit_en[d]) begin
          chk("pin_valid", d, int'(o_valid[d]), int'(lit_v[d]));
          if (lit_ht[d]) begin
            chk("pin_hit", d, int'(o_hit[d]), int'(lit_h[d]));
            chk("pin_target", d, o_tgt[d], lit_t[d]);
          end
        end
        if (lit_den[d]) chk("pin_init_done", d, int'(o_done[d]), int'(lit_d[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      lit_en[d]  = 0;
      lit_ht[d]  = 0;
      lit_den[d] = 0;
    end
  endtask

  task automatic pin_lu(input int d, input bit v, input bit ht, input bit h, input int t);
    lit_en[d] = 1; lit_v[d] = v; lit_ht[d] = ht; lit_h[d] = h; lit_t[d] = t;
  endtask

  task automatic pin_done(input int d, input bit v);
    lit_den[d] = 1; lit_d[d] = v;
  endtask

  task automatic idle();
    lu_en = 0; wr_en = 0; wr_clear = 0;
  endtask

  task automatic lookup(input int k);
    idle(); lu_en = 1; lu_key = 5'(k);
  endtask

  initial begin
    // reset for 3 cycles: all outputs zero
    idle();
    reset = 1;
    repeat (3) begin
      next_cycle();
      pin_lu(0, 0, 1, 0, 0);
      pin_done(0, 0);
    end
    // init sweep: lookups ignored, init_done after edge 32 (edge 16 for dut_b)
    reset = 0;
    lookup(2);
    for (int i = 1; i <= 32; i++) begin
      next_cycle();
      pin_done(0, i == 32);
      pin_done(1, i >= 16);
      pin_lu(0, 0, 1, 0, 0);
    end
    // back-to-back lookups
    lookup(2);  next_cycle(); pin_lu(0, 1, 1, 1, 108);
    lookup(3);  next_cycle(); pin_lu(0, 1, 1, 1, 18);
    lookup(10); next_cycle(); pin_lu(0, 1, 1, 1, 73);
    lookup(11); next_cycle(); pin_lu(0, 1, 1, 0, 0);
    idle();     next_cycle(); pin_lu(0, 0, 0, 0, 0);
    // write then read, and same-cycle write/lookup
    idle(); wr_en = 1; wr_key = 5'd11; wr_target = 12'd200;
    next_cycle(); pin_lu(0, 0, 0, 0, 0);
    lookup(11); next_cycle(); pin_lu(0, 1, 1, 1, 200);
    lookup(3); wr_en = 1; wr_key = 5'd3; wr_target = 12'd500;
    next_cycle(); pin_lu(0, 1, 1, 1, 500);
    // clear, and write+clear together
    idle(); wr_clear = 1; wr_key = 5'd4;
    next_cycle();
    lookup(4); next_cycle(); pin_lu(0, 1, 1, 0, 0);
    idle(); wr_en = 1; wr_clear = 1; wr_key = 5'd5; wr_target = 12'd9;
    next_cycle();
    lookup(5); next_cycle(); pin_lu(0, 1, 1, 1, 9); pin_lu(1, 1, 1, 1, 9);
    // key 20: in range for dut_a, dropped by dut_b
    idle(); wr_en = 1; wr_key = 5'd20; wr_target = 12'd77;
    next_cycle();
    lookup(20); next_cycle(); pin_lu(0, 1, 1, 1, 77); pin_lu(1, 1, 1, 0, 0);
    lookup(0);  next_cycle(); pin_lu(0, 1, 1, 1, 4);  pin_lu(1, 1, 1, 1, 4);
    // reset on sweep cycle 7
    idle(); reset = 1; next_cycle();
    reset = 0;
    repeat (7) next_cycle();
    reset = 1; next_cycle(); pin_done(0, 0); pin_lu(0, 0, 1, 0, 0);
    reset = 0;
    for (int i = 1; i <= 32; i++) begin
      next_cycle();
      pin_done(0, i == 32);
    end
    // runtime write discarded by reset in RUN
    idle(); wr_en = 1; wr_key = 5'd1; wr_target = 12'd99;
    next_cycle();
    lookup(1); next_cycle(); pin_lu(0, 1, 1, 1, 99);
    idle(); reset = 1; next_cycle(); pin_done(0, 0);
    reset = 0;
    for (int i = 1; i <= 32; i++) begin
      next_cycle();
      pin_done(0, i == 32);
    end
    lookup(1); next_cycle(); pin_lu(0, 1, 1, 1, 6); pin_lu(1, 1, 1, 1, 6);
    // randomized traffic, checked against the model every cycle
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 599) == 0);
      lu_en     = ($urandom_range(0, 9) < 7);
      wr_en     = ($urandom_range(0, 9) < 3);
      wr_clear  = ($urandom_range(0, 9) < 2);
      lu_key    = 5'($urandom_range(0, 31));
      wr_key    = ($urandom_range(0, 2) == 0) ? lu_key : 5'($urandom_range(0, 31));
      wr_target = 12'($urandom);
      next_cycle();
    end
    idle(); reset = 0;
    repeat (2) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
